// File: rtl/cust_gen_pkg.sv
// Shared definitions for the customer generator: field widths, FSM encoding,
// the customer payload and the ticket wrap helper.
package cust_gen_pkg;

    localparam int unsigned NUM_W  = 4;
    localparam int unsigned TIME_W = 4;
    localparam int unsigned ST_W   = 2;
    localparam int unsigned REJ_W  = 4;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE   = 2'd1;
    localparam logic [ST_W-1:0] ST_RELEASE = 2'd2;

    localparam logic [REJ_W-1:0] REJ_MAX = 4'd15;

    typedef struct packed {
        logic [NUM_W-1:0]  num;
        logic [TIME_W-1:0] svc_time;
    } cust_t;

    // Next ticket number: 1..tmax, then back to 1.
    function automatic logic [NUM_W-1:0] next_ticket(input logic [NUM_W-1:0] t,
                                                     input logic [NUM_W-1:0] tmax);
        return (t >= tmax) ? NUM_W'(1) : t + NUM_W'(1);
    endfunction

endpackage

// File: rtl/cust_gen_btn_debounce.sv
// Two-flop synchroniser plus counter debounce for the arrival button.
// Produces the accepted (stable) level and a one-cycle pulse on its rising edge.
module btn_debounce
    import cust_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has persisted DB_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            rise_q <= 1'b0;
            if (sync2 != level_q) begin
                if (cnt == CNT_LAST) begin
                    level_q <= sync2;
                    rise_q  <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cust_gen.sv
// Customer generator: turns debounced button presses into ticketed customers
// for the downstream queue, rejecting when the queue is full.
module cust_gen
    import cust_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned TICKET_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic [TIME_W-1:0] sw_time,
    input  logic              full_in,
    output logic              out_valid,
    output logic [NUM_W-1:0]  out_num,
    output logic [TIME_W-1:0] out_time,
    output logic              rej_pulse,
    output logic              err_pulse,
    output logic [REJ_W-1:0]  rej_cnt
);

    localparam logic [NUM_W-1:0] TICKET_TOP = NUM_W'(TICKET_MAX);

    logic              btn_level;
    logic              btn_rise;

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] time_nxt;
    logic [NUM_W-1:0]  ticket;
    logic [NUM_W-1:0]  ticket_nxt;
    cust_t             cust_q;
    cust_t             cust_nxt;
    logic              valid_nxt;
    logic              rej_nxt;
    logic              err_nxt;
    logic [REJ_W-1:0]  rej_cnt_nxt;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // FSM state register and the registered datapath / outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            time_q    <= '0;
            ticket    <= NUM_W'(1);
            cust_q    <= '0;
            out_valid <= 1'b0;
            rej_pulse <= 1'b0;
            err_pulse <= 1'b0;
            rej_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            time_q    <= time_nxt;
            ticket    <= ticket_nxt;
            cust_q    <= cust_nxt;
            out_valid <= valid_nxt;
            rej_pulse <= rej_nxt;
            err_pulse <= err_nxt;
            rej_cnt   <= rej_cnt_nxt;
        end
    end

    // Next-state and next-output decode; a press is served once, then the
    // button must be released before the next customer.
    always_comb begin
        state_nxt   = state;
        time_nxt    = time_q;
        ticket_nxt  = ticket;
        cust_nxt    = cust_q;
        valid_nxt   = 1'b0;
        rej_nxt     = 1'b0;
        err_nxt     = 1'b0;
        rej_cnt_nxt = rej_cnt;
        case (state)
            ST_IDLE: begin
                if (btn_rise) begin
                    if (sw_time == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        time_nxt  = sw_time;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!full_in) begin
                    valid_nxt         = 1'b1;
                    cust_nxt.num      = ticket;
                    cust_nxt.svc_time = time_q;
                    ticket_nxt        = next_ticket(ticket, TICKET_TOP);
                end else begin
                    rej_nxt = 1'b1;
                    if (rej_cnt != REJ_MAX) begin
                        rej_cnt_nxt = rej_cnt + REJ_W'(1);
                    end
                end
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!btn_level) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_num  = cust_q.num;
    assign out_time = cust_q.svc_time;

endmodule

// File: tb/tb_cust_gen.sv
// Self-checking bench for cust_gen: table-driven presses plus hand-written
// corner sequences, with a scoreboard matching every output pulse.
module tb_cust_gen;

    localparam int K_ISS = 0;
    localparam int K_REJ = 1;
    localparam int K_ERR = 2;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [3:0] sw_time;
    logic       full_in;
    logic       out_valid;
    logic [3:0] out_num;
    logic [3:0] out_time;
    logic       rej_pulse;
    logic       err_pulse;
    logic [3:0] rej_cnt;

    typedef struct {
        int kind;
        int num;
        int tm;
        int rcnt;
    } exp_t;

    typedef struct {
        int sw;
        int full;
        int kind;
        int num;
        int tm;
        int rcnt;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    int n_valid  = 0;
    int m_ticket = 1;
    int m_rej    = 0;

    cust_gen #(
        .DB_CYCLES  (4),
        .TICKET_MAX (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .sw_time   (sw_time),
        .full_in   (full_in),
        .out_valid (out_valid),
        .out_num   (out_num),
        .out_time  (out_time),
        .rej_pulse (rej_pulse),
        .err_pulse (err_pulse),
        .rej_cnt   (rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   k;
        if (!rst && (out_valid || rej_pulse || err_pulse)) begin
            n_pulse++;
            if (out_valid) n_valid++;
            k = out_valid ? K_ISS : (rej_pulse ? K_REJ : K_ERR);
            if (sb.size() == 0) begin
                check("unexpected_pulse_kind", k, -1);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", k, e.kind);
                if (e.kind == K_ISS) begin
                    check("out_num", int'(out_num), e.num);
                    check("out_time", int'(out_time), e.tm);
                end else if (e.kind == K_REJ) begin
                    check("rej_cnt_at_reject", int'(rej_cnt), e.rcnt);
                end
            end
        end
    end

    task automatic push_exp(input int kind, input int num, input int tm, input int rcnt);
        exp_t e;
        e.kind = kind; e.num = num; e.tm = tm; e.rcnt = rcnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ticket = 1;
        m_rej    = 0;
        sb.delete();
    endtask

    task automatic apply_press(input int sw, input int full);
        @(posedge clk); #1;
        sw_time = 4'(sw);
        full_in = 1'(full);
        btn     = 1'b1;
        repeat (12) @(posedge clk);
        #1 btn = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    // Predicts the outcome of one press from the bench's own ticket/reject model.
    task automatic model_press(input int sw, input int full);
        if (sw == 0) begin
            push_exp(K_ERR, 0, 0, m_rej);
        end else if (full != 0) begin
            m_rej = (m_rej < 15) ? m_rej + 1 : 15;
            push_exp(K_REJ, 0, 0, m_rej);
        end else begin
            push_exp(K_ISS, m_ticket, sw, m_rej);
            m_ticket = (m_ticket >= 15) ? 1 : m_ticket + 1;
        end
        apply_press(sw, full);
        drain("model_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int v0;
        int p0;
        int last_num;
        int last_tm;

        tbl[0] = '{sw: 3,  full: 0, kind: K_ISS, num: 1, tm: 3,  rcnt: 0};
        tbl[1] = '{sw: 0,  full: 0, kind: K_ERR, num: 0, tm: 0,  rcnt: 0};
        tbl[2] = '{sw: 5,  full: 1, kind: K_REJ, num: 0, tm: 0,  rcnt: 1};
        tbl[3] = '{sw: 7,  full: 0, kind: K_ISS, num: 2, tm: 7,  rcnt: 1};
        tbl[4] = '{sw: 15, full: 0, kind: K_ISS, num: 3, tm: 15, rcnt: 1};
        tbl[5] = '{sw: 1,  full: 1, kind: K_REJ, num: 0, tm: 0,  rcnt: 2};
        tbl[6] = '{sw: 0,  full: 1, kind: K_ERR, num: 0, tm: 0,  rcnt: 2};
        tbl[7] = '{sw: 1,  full: 0, kind: K_ISS, num: 4, tm: 1,  rcnt: 2};

        clk = 1'b0; rst = 1'b1; btn = 1'b0; sw_time = 4'd0; full_in = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_rej_pulse", int'(rej_pulse), 0);
        check("rst_err_pulse", int'(err_pulse), 0);
        check("rst_out_num",   int'(out_num),   0);
        check("rst_out_time",  int'(out_time),  0);
        check("rst_rej_cnt",   int'(rej_cnt),   0);
        rst = 1'b0;

        // Single held press: latency from the btn edge and exactly one customer.
        repeat (2) @(posedge clk);
        push_exp(K_ISS, 1, 3, 0);
        v0 = n_valid;
        @(posedge clk); #1;
        sw_time = 4'd3; full_in = 1'b0; btn = 1'b1;
        lat = 0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (out_valid) lat = c;
        end
        if (lat < 6 || lat > 8) $display("FAIL latency: got %0d cycles, expected 6..8", lat);
        check("latency_in_window", int'(lat >= 6 && lat <= 8), 1);
        repeat (20) @(posedge clk);
        #1 btn = 1'b0;
        repeat (12) @(posedge clk);
        drain("latency_drain");
        check("held_single_valid", n_valid - v0, 1);
        #1;
        check("hold_out_num",  int'(out_num),  1);
        check("hold_out_time", int'(out_time), 3);

        // Table of presses from a fresh reset.
        do_reset();
        last_num = 0;
        last_tm  = 0;
        for (int i = 0; i < 8; i++) begin
            push_exp(tbl[i].kind, tbl[i].num, tbl[i].tm, tbl[i].rcnt);
            apply_press(tbl[i].sw, tbl[i].full);
            drain("tbl_drain");
            if (tbl[i].kind == K_ISS) begin
                last_num = tbl[i].num;
                last_tm  = tbl[i].tm;
            end
            #1;
            check("tbl_rej_cnt",   int'(rej_cnt),  tbl[i].rcnt);
            check("tbl_hold_num",  int'(out_num),  last_num);
            check("tbl_hold_time", int'(out_time), last_tm);
        end

        // Bouncing button: toggles every 2 cycles must never form a press.
        p0 = n_pulse;
        sw_time = 4'd3; full_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 btn = ~btn;
            @(posedge clk);
        end
        #1 btn = 1'b0;
        repeat (15) @(posedge clk);
        check("bounce_no_pulses", n_pulse - p0, 0);

        // Ticket wrap: 1..15 then 1.
        do_reset();
        for (int i = 0; i < 16; i++) model_press(2, 0);
        #1 check("wrap_last_num", int'(out_num), 1);

        // Rejection does not consume a ticket.
        do_reset();
        model_press(4, 1);
        #1 check("rej_cnt_one", int'(rej_cnt), 1);
        model_press(4, 0);
        #1 check("after_rej_num", int'(out_num), 1);

        // Zero service time is ignored; reject counter saturates.
        do_reset();
        model_press(0, 0);
        model_press(5, 0);
        #1 check("after_err_num", int'(out_num), 1);
        for (int i = 0; i < 17; i++) model_press(3, 1);
        #1 check("rej_cnt_sat", int'(rej_cnt), 15);
        model_press(6, 0);
        #1 check("after_sat_num", int'(out_num), 2);

        // Reset during debounce with the button held.
        do_reset();
        v0 = n_valid;
        @(posedge clk); #1;
        sw_time = 4'd9; full_in = 1'b0; btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        push_exp(K_ISS, 1, 9, 0);
        repeat (14) @(posedge clk);
        #1 btn = 1'b0;
        repeat (12) @(posedge clk);
        drain("rst_debounce_drain");
        check("rst_debounce_valids", n_valid - v0, 1);

        // Reset during ISSUE with the button held.
        do_reset();
        v0 = n_valid;
        @(posedge clk); #1;
        sw_time = 4'd4; full_in = 1'b0; btn = 1'b1;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        push_exp(K_ISS, 1, 4, 0);
        repeat (14) @(posedge clk);
        #1 btn = 1'b0;
        repeat (12) @(posedge clk);
        drain("rst_issue_drain");
        check("rst_issue_valids", n_valid - v0, 1);
        #1 check("rst_issue_num", int'(out_num), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cust_gen.md
CUST_GEN -- requirements
Module: cust_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive clk cycles the synchronised button must hold a new level before it is accepted.
REQ-002 Parameter TICKET_MAX, default 15, highest ticket number issued before wrapping to 1.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 btn  input  1  raw, asynchronous customer-arrival push button (bouncy).
REQ-006 sw_time  input  4  requested service time in clock-counter units, sampled at the press event.
REQ-007 full_in  input  1  high when the downstream counters are all busy and the queue is full; a customer issued now would be dropped.
REQ-008 out_valid  output  1  one-cycle pulse presenting a customer to the downstream queue stage.
REQ-009 out_num  output  4  ticket number of the presented customer, range 1..TICKET_MAX.
REQ-010 out_time  output  4  service time of the presented customer, range 1..15.
REQ-011 rej_pulse  output  1  one-cycle pulse when a press is rejected because full_in was high.
REQ-012 err_pulse  output  1  one-cycle pulse when a press is ignored because sw_time was 0.
REQ-013 rej_cnt  output  4  saturating count of rejected customers.

Function
REQ-014 btn SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 Debounce: a counter SHALL increment while synced btn differs from the stable level, clear whenever they match, and flip the stable level when it reaches DB_CYCLES-1 with the mismatch still present.
REQ-016 Press event SHALL be a one-cycle rising edge of the stable level; a glitch shorter than DB_CYCLES cycles SHALL produce no event.
REQ-017 FSM states SHALL be IDLE, ISSUE, RELEASE.
REQ-018 IDLE: on a press event with sw_time=0, pulse err_pulse next cycle and stay in IDLE; with sw_time nonzero, latch sw_time and go to ISSUE.
REQ-019 ISSUE lasts exactly one cycle; if full_in=0, out_valid=1 with out_num=current ticket and out_time=latched time; else rej_pulse=1, rej_cnt increments, and out_valid stays 0; then go to RELEASE.
REQ-020 The ticket SHALL advance only on an issued customer: 1,2,...,TICKET_MAX, then 1; rejected or erroneous presses SHALL NOT consume a ticket.
REQ-021 RELEASE: stay until the stable level is low, then return to IDLE; the button SHALL be released before another customer can be generated.
REQ-022 Latency: out_valid or rej_pulse SHALL assert in the cycle after the press-event cycle; full_in SHALL be sampled in the ISSUE cycle.
REQ-023 rej_cnt SHALL saturate at 15.
REQ-024 out_num and out_time SHALL hold their last issued values while out_valid=0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst=1: FSM=IDLE, synchroniser and stable level=0, debounce counter=0, ticket=1, rej_cnt=0, and out_valid, rej_pulse, err_pulse, out_num, out_time all 0.
REQ-027 Reset asserted mid-debounce or in ISSUE SHALL abort the operation with no output pulse; after release, a button still held SHALL be debounced afresh and produce one press event.

Structure
REQ-028 The shared queue package SHALL hold the 4-bit NUM_W/TIME_W width constants and the FSM state encoding.
REQ-029 The synchroniser and debounce logic SHALL be a sub-module named btn_debounce, with DB_CYCLES as a parameter and outputs for the stable level and the rise pulse.

Verification (DB_CYCLES=4)
REQ-030 rst released; btn held high 20 cycles with sw_time=3, full_in=0 -> exactly one out_valid pulse with out_num=1 and out_time=3, 2+4+1 cycles after the btn edge (within ±1 cycle).
REQ-031 btn toggled every 2 cycles for 20 cycles -> no out_valid, err_pulse or rej_pulse.
REQ-032 Sixteen clean presses with sw_time=2 -> out_num sequence 1..15 then 1.
REQ-033 Press with full_in=1 -> rej_pulse once, rej_cnt=1, no out_valid; next press with full_in=0 -> out_num=1, so the ticket was not consumed.
REQ-034 Press with sw_time=0 -> err_pulse once, no out_valid, ticket unchanged; 17 rejected presses -> rej_cnt=15.
REQ-035 rst pulsed while btn is held during debounce -> no output pulse; after rst falls, one out_valid with out_num=1.
